cpu_ctrl_unit: RTL and testbench
================================

Name: cpu_ctrl_unit

Overview:
- Multi-cycle control sequencer for the 14-bit-instruction, 8-bit CPU datapath: program ROM, MAR/PC/IR, W register, 10-function ALU, 128x8 single-port RAM.
- Replaces the inline control FSM in the CPU top level.
- Decodes IR, drives all datapath load and select strobes, and adds four capabilities:
  - skip instructions (DECFSZ, INCFSZ, BTFSC, BTFSS)
  - bit set/clear (BCF, BSF)
  - CALL, RETURN and RETLW, with an internal return-stack pointer
  - a halt/single-step hook

Parameters:
- STACK_DEPTH, 8, number of return-stack entries; must be a power of two, minimum 2.
- SP_W, $clog2(STACK_DEPTH), width of the stack pointer.

Ports:
- clk  in  1  system clock, rising-edge.
- rst  in  1  synchronous, active-high reset.
- ir_q  in  14  current instruction register contents.
- alu_zero  in  1  datapath ALU result == 0 (combinational, valid in T4).
- bit_val  in  1  RAM bit ram_out[ir_q[9:7]] (combinational, valid in T4).
- halt  in  1  when 1, the sequencer parks in T6 after completing the current instruction.
- load_mar  out  1  MAR <= PC.
- load_pc  out  1  PC update, using the source selected by sel_pc.
- sel_pc  out  2  PC source: 0 = PC+1, 1 = ir_q[10:0], 2 = stack top.
- load_ir  out  1  IR <= ROM data.
- load_w  out  1  W <= ALU result.
- op  out  4  ALU function code.
- sel_alu  out  1  ALU A operand: 0 = ir_q[7:0], 1 = RAM data.
- sel_ram_mux  out  2  ALU A source from RAM: 0 = RAM data, 1 = bit-cleared RAM data, 2 = bit-set RAM data.
- sel_bit  out  3  bit index, = ir_q[9:7].
- ram_en  out  1  RAM write enable.
- sel_bus  out  1  RAM write data: 0 = ALU result, 1 = W.
- push  out  1  write PC to stack[sp], then sp+1.
- pop  out  1  sp-1, and the stack top becomes the PC source.
- stk_ptr  out  SP_W  current stack pointer.
- stk_ovf  out  1  sticky push-overflow flag.
- stk_unf  out  1  sticky pop-underflow flag.
- halted  out  1  1 while parked in T6 because halt=1.

Behaviour:
- Reset:
  - state = T0, skip_q = 0, stk_ptr = 0, stk_ovf = 0, stk_unf = 0.
  - All strobes are 0 in T0. Reset mid-instruction aborts it; no strobe is asserted in the reset cycle.
- Default value of every output strobe is 0 in every state. Outputs are Moore/Mealy combinational from state and ir_q.
- States: T0 → T1 → T2 → T3 → T4 → T5 → T6 → T1.
  - T0: no strobes.
  - T1: load_mar = 1.
  - T2: load_pc = 1, sel_pc = 0.
  - T3: load_ir = 1.
  - T4: execute (decode table below).
  - T5: if skip_q, load_pc = 1 and sel_pc = 0. skip_q clears on leaving T5.
  - T6: → T1 if halt = 0. Otherwise stay in T6 with halted = 1.
- Instruction latency is 6 cycles, T1..T6. Deasserting halt resumes in the next cycle.
- ALU op codes: 0 add, 1 sub, 2 and, 3 ior, 4 xor, 5 pass, 6 inc, 7 dec, 8 zero, 9 com.
- d = ir_q[7]. A "d-write" is: ram_en = 1 with sel_bus = 0 if d = 1, else load_w = 1.
- T4 decode (ir_q fields):
  - Literal ops, all with load_w = 1:
    - MOVLW 110000: op 5.
    - ADDLW 111110: op 0.
    - SUBLW 111100: op 1.
    - ANDLW 111001: op 2.
    - IORLW 111000: op 3.
    - XORLW 111010: op 4.
  - RETLW 1101xx: op 5, load_w, pop, load_pc, sel_pc = 2.
  - Branches:
    - GOTO 101: load_pc, sel_pc = 1.
    - CALL 100: push, load_pc, sel_pc = 1.
  - RETURN, ir_q == 14'h0008: pop, load_pc, sel_pc = 2.
  - NOP: ir_q[13:7] == 0 and not RETURN; no strobes.
  - MOVWF 0000001: ram_en, sel_bus = 1.
  - Register ops, all with sel_alu = 1 and a d-write:
    - ADDWF 000111: op 0.
    - SUBWF 000010: op 1.
    - ANDWF 000101: op 2.
    - IORWF 000100: op 3.
    - XORWF 000110: op 4.
    - MOVF 001000: op 5.
    - INCF 001010: op 6.
    - DECF 000011: op 7.
    - COMF 001001: op 9.
  - Clears:
    - CLRW (ir_q[13:2] == 12'h040): op 8, load_w.
    - CLRF (000001, d = 1): op 8, ram_en.
  - Skip-on-zero, sel_alu = 1 plus a d-write; skip_q <= alu_zero:
    - INCFSZ 001111: op 6.
    - DECFSZ 001011: op 7.
  - Bit set/clear, op 5, sel_alu = 1, ram_en = 1, sel_bus = 0:
    - BCF 0100: sel_ram_mux = 1.
    - BSF 0101: sel_ram_mux = 2.
  - Bit tests, sel_alu = 1, no write:
    - BTFSC 0110: skip_q <= ~bit_val.
    - BTFSS 0111: skip_q <= bit_val.
  - Any other encoding: treated as NOP.
- Stack:
  - Push at stk_ptr = STACK_DEPTH-1 wraps stk_ptr to 0 and sets stk_ovf.
  - Pop at stk_ptr = 0 wraps stk_ptr to STACK_DEPTH-1 and sets stk_unf.
  - Both flags clear only on rst.
- halt during T1..T5 has no effect until T6.

Decomposition:
- Shared package cpu_pkg holds:
  - state_e (T0..T6)
  - alu_op_e (ALU_ADD..ALU_COM, values 0..9)
  - pc_sel_e
  - ram_mux_e
  - opcode prefix localparams
- One natural sub-module: cpu_ir_decode, a combinational ir_q → one-hot instruction flags and d. The FSM, skip_q and stack pointer stay in cpu_ctrl_unit.

Test Plan:
- Reset, then MOVLW 0x3C (ir 0x303C): T1 load_mar, T2 load_pc, T3 load_ir, T4 load_w=1 with op=5 and sel_alu=0; T0 lasts one cycle; 6-cycle period.
- ADDWF 0x20, d=1 (0x07A0): T4 op=0, sel_alu=1, ram_en=1, sel_bus=0, load_w=0. Same with d=0 (0x0720): load_w=1, ram_en=0.
- DECFSZ 0x21 (0x0BA1) with alu_zero=1: T5 load_pc=1. With alu_zero=0: T5 has no strobes. BTFSS (0x1C21) with bit_val=1 skips.
- CALL 0x123 (0x2123): push, load_pc, sel_pc=1, stk_ptr 0→1. Then RETURN (0x0008): pop, sel_pc=2, stk_ptr→0.
- Nine CALLs with STACK_DEPTH=8: stk_ptr wraps to 1 and stk_ovf=1. RETURN at stk_ptr=0: stk_unf=1. rst clears both flags.
- halt=1 asserted in T3: instruction completes, FSM holds in T6 with halted=1 for N cycles and no strobes; halt=0 → next cycle is T1. rst asserted in T4 → next cycle is T0 with all strobes 0.

Source files
------------

// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg
// Shared types and opcode prefixes for the multi-cycle CPU control sequencer.
// Contents:
//   state_e    sequencer states T0..T6
//   alu_op_e   ALU function codes 0..9
//   pc_sel_e   PC source select (PC+1, IR target, stack top)
//   ram_mux_e  RAM-side ALU operand select (direct, bit-cleared, bit-set)
//   instr_t    one-hot decoded instruction flags
//   OPC_*      opcode prefixes matched against the top bits of ir_q
// ---------------------------------------------------------------------------
package cpu_pkg;

  typedef enum logic [2:0] {
    T0 = 3'd0, T1 = 3'd1, T2 = 3'd2, T3 = 3'd3,
    T4 = 3'd4, T5 = 3'd5, T6 = 3'd6
  } state_e;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2, ALU_IOR = 4'd3,
    ALU_XOR  = 4'd4, ALU_PASS = 4'd5, ALU_INC = 4'd6, ALU_DEC = 4'd7,
    ALU_ZERO = 4'd8, ALU_COM = 4'd9
  } alu_op_e;

  typedef enum logic [1:0] {
    PC_INC = 2'd0, PC_IR = 2'd1, PC_STACK = 2'd2
  } pc_sel_e;

  typedef enum logic [1:0] {
    RAM_DIRECT = 2'd0, RAM_BIT_CLR = 2'd1, RAM_BIT_SET = 2'd2
  } ram_mux_e;

  // Literal and register ops are identified by ir_q[13:8].
  localparam logic [5:0] OPC_MOVLW  = 6'b110000;
  localparam logic [5:0] OPC_ADDLW  = 6'b111110;
  localparam logic [5:0] OPC_SUBLW  = 6'b111100;
  localparam logic [5:0] OPC_ANDLW  = 6'b111001;
  localparam logic [5:0] OPC_IORLW  = 6'b111000;
  localparam logic [5:0] OPC_XORLW  = 6'b111010;
  localparam logic [5:0] OPC_ADDWF  = 6'b000111;
  localparam logic [5:0] OPC_SUBWF  = 6'b000010;
  localparam logic [5:0] OPC_ANDWF  = 6'b000101;
  localparam logic [5:0] OPC_IORWF  = 6'b000100;
  localparam logic [5:0] OPC_XORWF  = 6'b000110;
  localparam logic [5:0] OPC_MOVF   = 6'b001000;
  localparam logic [5:0] OPC_INCF   = 6'b001010;
  localparam logic [5:0] OPC_DECF   = 6'b000011;
  localparam logic [5:0] OPC_COMF   = 6'b001001;
  localparam logic [5:0] OPC_CLRF   = 6'b000001;
  localparam logic [5:0] OPC_INCFSZ = 6'b001111;
  localparam logic [5:0] OPC_DECFSZ = 6'b001011;
  // Bit ops and RETLW are identified by ir_q[13:10].
  localparam logic [3:0] OPC_RETLW  = 4'b1101;
  localparam logic [3:0] OPC_BCF    = 4'b0100;
  localparam logic [3:0] OPC_BSF    = 4'b0101;
  localparam logic [3:0] OPC_BTFSC  = 4'b0110;
  localparam logic [3:0] OPC_BTFSS  = 4'b0111;
  // Branches are identified by ir_q[13:11].
  localparam logic [2:0] OPC_GOTO   = 3'b101;
  localparam logic [2:0] OPC_CALL   = 3'b100;
  // Full or near-full matches.
  localparam logic [6:0]  OPC_MOVWF  = 7'b0000001;
  localparam logic [11:0] OPC_CLRW   = 12'h040;
  localparam logic [13:0] OPC_RETURN = 14'h0008;

  typedef struct packed {
    logic movlw;  logic addlw;  logic sublw;  logic andlw;
    logic iorlw;  logic xorlw;  logic retlw;  logic jump;
    logic call;   logic ret;    logic movwf;  logic addwf;
    logic subwf;  logic andwf;  logic iorwf;  logic xorwf;
    logic movf;   logic incf;   logic decf;   logic comf;
    logic clrw;   logic clrf;   logic incfsz; logic decfsz;
    logic bcf;    logic bsf;    logic btfsc;  logic btfss;
  } instr_t;

endpackage

// File: rtl/cpu_ir_decode.sv
// ---------------------------------------------------------------------------
// cpu_ir_decode
// Purely combinational instruction decoder: turns the 14-bit instruction
// register into one-hot instruction flags plus the destination bit d.
// Ports:
//   i_ir_q     in  14  instruction register contents
//   o_instr    out     one-hot instruction flags (all zero means NOP)
//   o_d        out  1  destination select, ir_q[7] (1 = RAM, 0 = W)
// ---------------------------------------------------------------------------
module cpu_ir_decode
  import cpu_pkg::*;
(
  input  logic [13:0] i_ir_q,
  output instr_t      o_instr,
  output logic        o_d
);

  logic [5:0] w_op6;
  logic [3:0] w_op4;
  logic [2:0] w_op3;

  assign w_op6 = i_ir_q[13:8];
  assign w_op4 = i_ir_q[13:10];
  assign w_op3 = i_ir_q[13:11];
  assign o_d   = i_ir_q[7];

  // Every prefix is distinct, so at most one flag is ever set; anything
  // that matches nothing falls through as a NOP.
  assign o_instr.movlw  = (w_op6 == OPC_MOVLW);
  assign o_instr.addlw  = (w_op6 == OPC_ADDLW);
  assign o_instr.sublw  = (w_op6 == OPC_SUBLW);
  assign o_instr.andlw  = (w_op6 == OPC_ANDLW);
  assign o_instr.iorlw  = (w_op6 == OPC_IORLW);
  assign o_instr.xorlw  = (w_op6 == OPC_XORLW);
  assign o_instr.retlw  = (w_op4 == OPC_RETLW);
  assign o_instr.jump   = (w_op3 == OPC_GOTO);
  assign o_instr.call   = (w_op3 == OPC_CALL);
  assign o_instr.ret    = (i_ir_q == OPC_RETURN);
  assign o_instr.movwf  = (i_ir_q[13:7] == OPC_MOVWF);
  assign o_instr.addwf  = (w_op6 == OPC_ADDWF);
  assign o_instr.subwf  = (w_op6 == OPC_SUBWF);
  assign o_instr.andwf  = (w_op6 == OPC_ANDWF);
  assign o_instr.iorwf  = (w_op6 == OPC_IORWF);
  assign o_instr.xorwf  = (w_op6 == OPC_XORWF);
  assign o_instr.movf   = (w_op6 == OPC_MOVF);
  assign o_instr.incf   = (w_op6 == OPC_INCF);
  assign o_instr.decf   = (w_op6 == OPC_DECF);
  assign o_instr.comf   = (w_op6 == OPC_COMF);
  assign o_instr.clrw   = (i_ir_q[13:2] == OPC_CLRW);
  // CLRF shares its prefix with CLRW; only the d=1 form clears RAM.
  assign o_instr.clrf   = (w_op6 == OPC_CLRF) && i_ir_q[7];
  assign o_instr.incfsz = (w_op6 == OPC_INCFSZ);
  assign o_instr.decfsz = (w_op6 == OPC_DECFSZ);
  assign o_instr.bcf    = (w_op4 == OPC_BCF);
  assign o_instr.bsf    = (w_op4 == OPC_BSF);
  assign o_instr.btfsc  = (w_op4 == OPC_BTFSC);
  assign o_instr.btfss  = (w_op4 == OPC_BTFSS);

endmodule

// File: rtl/cpu_ctrl_unit.sv
// ---------------------------------------------------------------------------
// cpu_ctrl_unit
// Multi-cycle control sequencer for the 8-bit CPU datapath. Steps through
// T0 (post-reset) then T1..T6 per instruction, drives every datapath strobe,
// handles skip instructions, bit set/clear, CALL/RETURN/RETLW with a
// return-stack pointer, and a halt/single-step hook parked in T6.
// Ports:
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_ir_q [13:0]         instruction register
//   i_alu_zero, i_bit_val ALU zero flag and tested RAM bit, valid in T4
//   i_halt                park in T6 after the current instruction
//   o_load_mar/pc/ir/w    datapath register load strobes
//   o_sel_pc [1:0]        PC source (PC+1, IR target, stack top)
//   o_op [3:0]            ALU function
//   o_sel_alu             ALU A operand (0 literal, 1 RAM)
//   o_sel_ram_mux [1:0]   RAM operand (direct, bit-cleared, bit-set)
//   o_sel_bit [2:0]       bit index, ir_q[9:7]
//   o_ram_en, o_sel_bus   RAM write enable and write-data select
//   o_push, o_pop         return-stack operations
//   o_stk_ptr             stack pointer
//   o_stk_ovf, o_stk_unf  sticky overflow / underflow flags
//   o_halted              parked in T6 with halt asserted
// ---------------------------------------------------------------------------
module cpu_ctrl_unit
  import cpu_pkg::*;
#(
  parameter int STACK_DEPTH = 8,
  parameter int SP_W        = $clog2(STACK_DEPTH)
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic [13:0]     i_ir_q,
  input  logic            i_alu_zero,
  input  logic            i_bit_val,
  input  logic            i_halt,
  output logic            o_load_mar,
  output logic            o_load_pc,
  output logic [1:0]      o_sel_pc,
  output logic            o_load_ir,
  output logic            o_load_w,
  output logic [3:0]      o_op,
  output logic            o_sel_alu,
  output logic [1:0]      o_sel_ram_mux,
  output logic [2:0]      o_sel_bit,
  output logic            o_ram_en,
  output logic            o_sel_bus,
  output logic            o_push,
  output logic            o_pop,
  output logic [SP_W-1:0] o_stk_ptr,
  output logic            o_stk_ovf,
  output logic            o_stk_unf,
  output logic            o_halted
);

  localparam logic [SP_W-1:0] SP_MAX = SP_W'(STACK_DEPTH - 1);

  state_e          r_state;
  logic            r_skip;
  logic [SP_W-1:0] r_stk_ptr;
  logic            r_stk_ovf;
  logic            r_stk_unf;

  instr_t  w_instr;
  logic    w_d;
  logic    w_lit_op;
  logic    w_reg_op;
  alu_op_e w_alu_op;

  cpu_ir_decode u_decode (
    .i_ir_q  (i_ir_q),
    .o_instr (w_instr),
    .o_d     (w_d)
  );

  assign o_sel_bit = i_ir_q[9:7];
  assign o_stk_ptr = r_stk_ptr;
  assign o_stk_ovf = r_stk_ovf;
  assign o_stk_unf = r_stk_unf;

  assign w_lit_op = w_instr.movlw | w_instr.addlw | w_instr.sublw |
                    w_instr.andlw | w_instr.iorlw | w_instr.xorlw;
  // Register ops, including the skip-on-zero pair, all read RAM and
  // write their result to W or back to RAM depending on d.
  assign w_reg_op = w_instr.addwf | w_instr.subwf | w_instr.andwf |
                    w_instr.iorwf | w_instr.xorwf | w_instr.movf  |
                    w_instr.incf  | w_instr.decf  | w_instr.comf  |
                    w_instr.incfsz | w_instr.decfsz;

  // ALU function for the decoded instruction. Instructions that do not
  // use the ALU leave it at code 0 so the op bus idles at zero.
  always_comb begin
    w_alu_op = ALU_ADD;
    if (w_instr.sublw | w_instr.subwf)                   w_alu_op = ALU_SUB;
    if (w_instr.andlw | w_instr.andwf)                   w_alu_op = ALU_AND;
    if (w_instr.iorlw | w_instr.iorwf)                   w_alu_op = ALU_IOR;
    if (w_instr.xorlw | w_instr.xorwf)                   w_alu_op = ALU_XOR;
    if (w_instr.movlw | w_instr.retlw | w_instr.movf |
        w_instr.bcf | w_instr.bsf)                       w_alu_op = ALU_PASS;
    if (w_instr.incf | w_instr.incfsz)                   w_alu_op = ALU_INC;
    if (w_instr.decf | w_instr.decfsz)                   w_alu_op = ALU_DEC;
    if (w_instr.clrw | w_instr.clrf)                     w_alu_op = ALU_ZERO;
    if (w_instr.comf)                                    w_alu_op = ALU_COM;
  end

  // Strobe generation. Everything defaults to zero, and reset forces the
  // defaults so an aborted instruction never fires a strobe in the reset
  // cycle itself.
  always_comb begin
    o_load_mar    = 1'b0;
    o_load_pc     = 1'b0;
    o_sel_pc      = PC_INC;
    o_load_ir     = 1'b0;
    o_load_w      = 1'b0;
    o_op          = ALU_ADD;
    o_sel_alu     = 1'b0;
    o_sel_ram_mux = RAM_DIRECT;
    o_ram_en      = 1'b0;
    o_sel_bus     = 1'b0;
    o_push        = 1'b0;
    o_pop         = 1'b0;
    o_halted      = 1'b0;
    if (!i_rst) begin
      case (r_state)
        T1: o_load_mar = 1'b1;
        T2: o_load_pc  = 1'b1;
        T3: o_load_ir  = 1'b1;
        T4: begin
          o_op = w_alu_op;
          if (w_lit_op | w_instr.retlw | w_instr.clrw) o_load_w = 1'b1;
          if (w_instr.retlw | w_instr.ret) begin
            o_pop     = 1'b1;
            o_load_pc = 1'b1;
            o_sel_pc  = PC_STACK;
          end
          if (w_instr.jump | w_instr.call) begin
            o_push    = w_instr.call;
            o_load_pc = 1'b1;
            o_sel_pc  = PC_IR;
          end
          if (w_instr.movwf) begin
            o_ram_en  = 1'b1;
            o_sel_bus = 1'b1;
          end
          if (w_reg_op) begin
            o_sel_alu = 1'b1;
            o_ram_en  = w_d;
            o_load_w  = ~w_d;
          end
          if (w_instr.clrf) o_ram_en = 1'b1;
          if (w_instr.bcf | w_instr.bsf) begin
            o_sel_alu     = 1'b1;
            o_ram_en      = 1'b1;
            o_sel_ram_mux = w_instr.bcf ? RAM_BIT_CLR : RAM_BIT_SET;
          end
          if (w_instr.btfsc | w_instr.btfss) o_sel_alu = 1'b1;
        end
        T5: o_load_pc = r_skip;
        T6: o_halted  = i_halt;
        default: ;
      endcase
    end
  end

  // Sequencer state, skip latch and return-stack pointer. The skip
  // decision is captured at the end of T4 while alu_zero/bit_val are valid
  // and consumed in T5. The stack pointer wraps naturally because the depth
  // is a power of two; the flags only record that a wrap happened.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= T0;
      r_skip    <= 1'b0;
      r_stk_ptr <= '0;
      r_stk_ovf <= 1'b0;
      r_stk_unf <= 1'b0;
    end else begin
      case (r_state)
        T0: r_state <= T1;
        T1: r_state <= T2;
        T2: r_state <= T3;
        T3: r_state <= T4;
        T4: begin
          r_state <= T5;
          if (w_instr.incfsz | w_instr.decfsz) r_skip <= i_alu_zero;
          else if (w_instr.btfsc)              r_skip <= ~i_bit_val;
          else if (w_instr.btfss)              r_skip <= i_bit_val;
        end
        T5: begin
          r_state <= T6;
          r_skip  <= 1'b0;
        end
        T6: if (!i_halt) r_state <= T1;
        default: r_state <= T0;
      endcase
      if (o_push) begin
        if (r_stk_ptr == SP_MAX) r_stk_ovf <= 1'b1;
        r_stk_ptr <= r_stk_ptr + 1'b1;
      end
      if (o_pop) begin
        if (r_stk_ptr == '0) r_stk_unf <= 1'b1;
        r_stk_ptr <= r_stk_ptr - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cpu_ctrl_unit.sv
// ---------------------------------------------------------------------------
// tb_cpu_ctrl_unit
// Scoreboard bench for cpu_ctrl_unit: each stimulus cycle queues the
// hand-derived expected output vector, and a monitor on the falling edge
// pops and compares it against the DUT.
// ---------------------------------------------------------------------------
module tb_cpu_ctrl_unit;

  typedef struct packed {
    logic       loadMar;
    logic       loadPc;
    logic [1:0] selPc;
    logic       loadIr;
    logic       loadW;
    logic [3:0] op;
    logic       selAlu;
    logic [1:0] selRamMux;
    logic [2:0] selBit;
    logic       ramEn;
    logic       selBus;
    logic       push;
    logic       pop;
    logic [2:0] stkPtr;
    logic       stkOvf;
    logic       stkUnf;
    logic       halted;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [13:0] irQ;
  logic        aluZero;
  logic        bitVal;
  logic        halt;

  logic        o_load_mar, o_load_pc, o_load_ir, o_load_w;
  logic [1:0]  o_sel_pc, o_sel_ram_mux;
  logic [3:0]  o_op;
  logic        o_sel_alu, o_ram_en, o_sel_bus, o_push, o_pop;
  logic [2:0]  o_sel_bit, o_stk_ptr;
  logic        o_stk_ovf, o_stk_unf, o_halted;

  exp_t  expQ[$];
  string nameQ[$];
  int    compared   = 0;
  int    mismatched = 0;

  logic [2:0] expSp;
  logic       expOvf;
  logic       expUnf;

  always #5 clk = ~clk;

  cpu_ctrl_unit #(.STACK_DEPTH(8)) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_ir_q        (irQ),
    .i_alu_zero    (aluZero),
    .i_bit_val     (bitVal),
    .i_halt        (halt),
    .o_load_mar    (o_load_mar),
    .o_load_pc     (o_load_pc),
    .o_sel_pc      (o_sel_pc),
    .o_load_ir     (o_load_ir),
    .o_load_w      (o_load_w),
    .o_op          (o_op),
    .o_sel_alu     (o_sel_alu),
    .o_sel_ram_mux (o_sel_ram_mux),
    .o_sel_bit     (o_sel_bit),
    .o_ram_en      (o_ram_en),
    .o_sel_bus     (o_sel_bus),
    .o_push        (o_push),
    .o_pop         (o_pop),
    .o_stk_ptr     (o_stk_ptr),
    .o_stk_ovf     (o_stk_ovf),
    .o_stk_unf     (o_stk_unf),
    .o_halted      (o_halted)
  );

  // Quiet vector for a given instruction: no strobes, bit index from the
  // instruction, stack state as currently tracked by the bench.
  function automatic exp_t idle(input logic [13:0] ir);
    exp_t e;
    e        = '0;
    e.selBit = ir[9:7];
    e.stkPtr = expSp;
    e.stkOvf = expOvf;
    e.stkUnf = expUnf;
    return e;
  endfunction

  task automatic checkOutput(input string name, input exp_t e);
    exp_t act;
    act.loadMar   = o_load_mar;
    act.loadPc    = o_load_pc;
    act.selPc     = o_sel_pc;
    act.loadIr    = o_load_ir;
    act.loadW     = o_load_w;
    act.op        = o_op;
    act.selAlu    = o_sel_alu;
    act.selRamMux = o_sel_ram_mux;
    act.selBit    = o_sel_bit;
    act.ramEn     = o_ram_en;
    act.selBus    = o_sel_bus;
    act.push      = o_push;
    act.pop       = o_pop;
    act.stkPtr    = o_stk_ptr;
    act.stkOvf    = o_stk_ovf;
    act.stkUnf    = o_stk_unf;
    act.halted    = o_halted;
    compared++;
    if (act !== e) begin
      mismatched++;
      $display("[TB] FAIL %s: got %b required %b", name, act, e);
    end
  endtask

  // Monitor: the DUT presents a full output vector every cycle.
  always @(negedge clk) begin
    if (expQ.size() != 0) checkOutput(nameQ.pop_front(), expQ.pop_front());
  end

  task automatic applyStimulus(input string name, input logic [13:0] ir,
                               input logic az, input logic bv,
                               input logic hlt, input logic rs,
                               input exp_t e);
    irQ     = ir;
    aluZero = az;
    bitVal  = bv;
    halt    = hlt;
    rst     = rs;
    expQ.push_back(e);
    nameQ.push_back(name);
    @(posedge clk);
    #1;
  endtask

  // One full instruction T1..T6. t4 is the hand-derived execute vector;
  // spA/ovfA/unfA are the stack state expected from T5 onward.
  task automatic runInstr(input string name, input logic [13:0] ir,
                          input logic az, input logic bv, input exp_t t4,
                          input logic skip, input logic [2:0] spA,
                          input logic ovfA, input logic unfA,
                          input int haltCycles);
    exp_t e;
    logic h;
    h = (haltCycles > 0);
    e = idle(ir); e.loadMar = 1'b1;
    applyStimulus({name, " T1"}, ir, az, bv, 1'b0, 1'b0, e);
    e = idle(ir); e.loadPc = 1'b1;
    applyStimulus({name, " T2"}, ir, az, bv, 1'b0, 1'b0, e);
    e = idle(ir); e.loadIr = 1'b1;
    applyStimulus({name, " T3"}, ir, az, bv, h, 1'b0, e);
    applyStimulus({name, " T4"}, ir, az, bv, h, 1'b0, t4);
    expSp = spA; expOvf = ovfA; expUnf = unfA;
    e = idle(ir); e.loadPc = skip;
    applyStimulus({name, " T5"}, ir, az, bv, h, 1'b0, e);
    for (int i = 0; i < haltCycles; i++) begin
      e = idle(ir); e.halted = 1'b1;
      applyStimulus({name, " T6 parked"}, ir, az, bv, 1'b1, 1'b0, e);
    end
    e = idle(ir);
    applyStimulus({name, " T6"}, ir, az, bv, 1'b0, 1'b0, e);
  endtask

  initial begin
    #200000;
    mismatched++;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    exp_t t;
    expSp = 3'd0; expOvf = 1'b0; expUnf = 1'b0;
    rst = 1'b1; irQ = '0; aluZero = 1'b0; bitVal = 1'b0; halt = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    $display("[TB] reset released");

    applyStimulus("T0 after reset", 14'h0000, 1'b0, 1'b0, 1'b0, 1'b0, idle(14'h0000));

    t = idle(14'h303C); t.loadW = 1'b1; t.op = 4'd5;
    runInstr("MOVLW", 14'h303C, 1'b0, 1'b0, t, 1'b0, expSp, expOvf, expUnf, 0);

    t = idle(14'h07A0); t.op = 4'd0; t.selAlu = 1'b1; t.ramEn = 1'b1;
    runInstr("ADDWF d1", 14'h07A0, 1'b0, 1'b0, t, 1'b0, expSp, expOvf, expUnf, 0);

    t = idle(14'h0720); t.op = 4'd0; t.selAlu = 1'b1; t.loadW = 1'b1;
    runInstr("ADDWF d0", 14'h0720, 1'b0, 1'b0, t, 1'b0, expSp, expOvf, expUnf, 0);

    t = idle(14'h0BA1); t.op = 4'd7; t.selAlu = 1'b1; t.ramEn = 1'b1;
    runInstr("DECFSZ z1", 14'h0BA1, 1'b1, 1'b0, t, 1'b1, expSp, expOvf, expUnf, 0);
    runInstr("DECFSZ z0", 14'h0BA1, 1'b0, 1'b0, t, 1'b0, expSp, expOvf, expUnf, 0);

    t = idle(14'h1C21); t.selAlu = 1'b1;
    runInstr("BTFSS b1", 14'h1C21, 1'b0, 1'b1, t, 1'b1, expSp, expOvf, expUnf, 0);

    t = idle(14'h1BA1); t.selAlu = 1'b1;
    runInstr("BTFSC b1", 14'h1BA1, 1'b0, 1'b1, t, 1'b0, expSp, expOvf, expUnf, 0);

    t = idle(14'h1521); t.op = 4'd5; t.selAlu = 1'b1; t.ramEn = 1'b1; t.selRamMux = 2'd2;
    runInstr("BSF", 14'h1521, 1'b0, 1'b0, t, 1'b0, expSp, expOvf, expUnf, 0);

    t = idle(14'h1121); t.op = 4'd5; t.selAlu = 1'b1; t.ramEn = 1'b1; t.selRamMux = 2'd1;
    runInstr("BCF", 14'h1121, 1'b0, 1'b0, t, 1'b0, expSp, expOvf, expUnf, 0);

    t = idle(14'h00A5); t.ramEn = 1'b1; t.selBus = 1'b1;
    runInstr("MOVWF", 14'h00A5, 1'b0, 1'b0, t, 1'b0, expSp, expOvf, expUnf, 0);

    t = idle(14'h0100); t.op = 4'd8; t.loadW = 1'b1;
    runInstr("CLRW", 14'h0100, 1'b0, 1'b0, t, 1'b0, expSp, expOvf, expUnf, 0);

    t = idle(14'h01A0); t.op = 4'd8; t.ramEn = 1'b1;
    runInstr("CLRF", 14'h01A0, 1'b0, 1'b0, t, 1'b0, expSp, expOvf, expUnf, 0);

    t = idle(14'h0920); t.op = 4'd9; t.selAlu = 1'b1; t.loadW = 1'b1;
    runInstr("COMF d0", 14'h0920, 1'b0, 1'b0, t, 1'b0, expSp, expOvf, expUnf, 0);

    t = idle(14'h0F21); t.op = 4'd6; t.selAlu = 1'b1; t.loadW = 1'b1;
    runInstr("INCFSZ z1", 14'h0F21, 1'b1, 1'b0, t, 1'b1, expSp, expOvf, expUnf, 0);

    runInstr("NOP", 14'h0000, 1'b0, 1'b0, idle(14'h0000), 1'b0, expSp, expOvf, expUnf, 0);
    runInstr("UNDEF", 14'h3F00, 1'b1, 1'b1, idle(14'h3F00), 1'b0, expSp, expOvf, expUnf, 0);

    t = idle(14'h2ABC); t.loadPc = 1'b1; t.selPc = 2'd1;
    runInstr("GOTO", 14'h2ABC, 1'b0, 1'b0, t, 1'b0, expSp, expOvf, expUnf, 0);

    t = idle(14'h2123); t.push = 1'b1; t.loadPc = 1'b1; t.selPc = 2'd1;
    runInstr("CALL", 14'h2123, 1'b0, 1'b0, t, 1'b0, 3'd1, 1'b0, 1'b0, 0);

    t = idle(14'h0008); t.pop = 1'b1; t.loadPc = 1'b1; t.selPc = 2'd2;
    runInstr("RETURN", 14'h0008, 1'b0, 1'b0, t, 1'b0, 3'd0, 1'b0, 1'b0, 0);

    t = idle(14'h2123); t.push = 1'b1; t.loadPc = 1'b1; t.selPc = 2'd1;
    runInstr("CALL2", 14'h2123, 1'b0, 1'b0, t, 1'b0, 3'd1, 1'b0, 1'b0, 0);

    t = idle(14'h3455); t.op = 4'd5; t.loadW = 1'b1; t.pop = 1'b1; t.loadPc = 1'b1; t.selPc = 2'd2;
    runInstr("RETLW", 14'h3455, 1'b0, 1'b0, t, 1'b0, 3'd0, 1'b0, 1'b0, 0);

    for (int i = 0; i < 9; i++) begin
      t = idle(14'h2123); t.push = 1'b1; t.loadPc = 1'b1; t.selPc = 2'd1;
      runInstr($sformatf("CALL%0d", i), 14'h2123, 1'b0, 1'b0, t, 1'b0,
               3'((i + 1) % 8), (i >= 7), 1'b0, 0);
    end

    t = idle(14'h0008); t.pop = 1'b1; t.loadPc = 1'b1; t.selPc = 2'd2;
    runInstr("RETURN sp1", 14'h0008, 1'b0, 1'b0, t, 1'b0, 3'd0, 1'b1, 1'b0, 0);
    t = idle(14'h0008); t.pop = 1'b1; t.loadPc = 1'b1; t.selPc = 2'd2;
    runInstr("RETURN sp0", 14'h0008, 1'b0, 1'b0, t, 1'b0, 3'd7, 1'b1, 1'b1, 0);

    t = idle(14'h2123); t.loadMar = 1'b1;
    applyStimulus("RSTCALL T1", 14'h2123, 1'b0, 1'b0, 1'b0, 1'b0, t);
    t = idle(14'h2123); t.loadPc = 1'b1;
    applyStimulus("RSTCALL T2", 14'h2123, 1'b0, 1'b0, 1'b0, 1'b0, t);
    t = idle(14'h2123); t.loadIr = 1'b1;
    applyStimulus("RSTCALL T3", 14'h2123, 1'b0, 1'b0, 1'b0, 1'b0, t);
    applyStimulus("RSTCALL T4 in reset", 14'h2123, 1'b0, 1'b0, 1'b0, 1'b1, idle(14'h2123));
    expSp = 3'd0; expOvf = 1'b0; expUnf = 1'b0;
    applyStimulus("T0 after mid reset", 14'h2123, 1'b0, 1'b0, 1'b0, 1'b0, idle(14'h2123));

    t = idle(14'h303C); t.loadW = 1'b1; t.op = 4'd5;
    runInstr("MOVLW halt", 14'h303C, 1'b0, 1'b0, t, 1'b0, expSp, expOvf, expUnf, 3);

    t = idle(14'h303C); t.loadMar = 1'b1;
    applyStimulus("resume T1", 14'h303C, 1'b0, 1'b0, 1'b0, 1'b0, t);

    for (int i = 0; i < 10 && expQ.size() != 0; i++) @(negedge clk);
    if (expQ.size() != 0) begin
      mismatched++;
      $display("[TB] FAIL drain: %0d expectations never compared", expQ.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
